// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit.
//   Accepts an operation in IDLE, iterates one bit per cycle for 32 cycles
//   (shift-add multiply or restoring divide on operand magnitudes), then
//   issues a single-cycle write-back. Divide-by-zero and signed overflow
//   skip the iteration and complete one cycle after issue.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, op       issue request (sampled in IDLE) and RV32M funct3
//   rs1_val/rs2_val operands A and B, rd_in destination index
//   kill            flush: abort in-flight op, suppress done/reg_we this cycle
//   busy            high in CALC and DONE
//   done, rd, rd_val, reg_we   write-back strobe, index, data, bank enable
module muldiv_unit #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [XLEN-1:0]   rs1_val,
   input  logic [XLEN-1:0]   rs2_val,
   input  logic [ADDR_W-1:0] rd_in,
   input  logic              kill,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rd,
   output logic [XLEN-1:0]   rd_val,
   output logic              reg_we
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state_q, state_d;
   logic [4:0]          cnt_q, cnt_d;
   logic [2:0]          op_q, op_d;
   logic [XLEN-1:0]     b_q, b_d;        // divisor / multiplicand magnitude
   logic [2*XLEN-1:0]   p_q, p_d;        // {acc_hi, multiplier} or {remainder, quotient}
   logic                neg_q, neg_d;    // negate result on entry to DONE
   logic [ADDR_W-1:0]   rd_lat_q, rd_lat_d;
   logic [ADDR_W-1:0]   rd_q, rd_d;
   logic [XLEN-1:0]     rd_val_q, rd_val_d;
   logic                done_q, done_d;
   logic                we_q, we_d;

   // ---- issue-side decode on the live inputs ----
   logic              a_sgn_op, b_sgn_op, a_neg, b_neg, div_zero, div_ovf;
   logic [XLEN-1:0]   a_mag, b_mag, fast_res;

   // MUL is treated as signed x signed; its low half is identical either way.
   assign a_sgn_op = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
   assign b_sgn_op = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
   assign a_neg    = a_sgn_op & rs1_val[XLEN-1];
   assign b_neg    = b_sgn_op & rs2_val[XLEN-1];
   assign a_mag    = a_neg ? (~rs1_val + 1'b1) : rs1_val;
   assign b_mag    = b_neg ? (~rs2_val + 1'b1) : rs2_val;
   assign div_zero = op[2] && (rs2_val == '0);
   assign div_ovf  = op[2] && !op[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);

   always_comb begin
      fast_res = '0;
      if (div_zero)
         fast_res = op[1] ? rs1_val : '1;
      else if (!op[1])
         fast_res = {1'b1, {(XLEN-1){1'b0}}};
   end

   // ---- one iteration step ----
   logic [XLEN:0]     mul_sum, div_sh, div_diff;
   logic [2*XLEN-1:0] step;

   assign mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, b_q} : '0);
   assign div_sh   = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
   assign div_diff = div_sh - {1'b0, b_q};

   always_comb begin
      if (!op_q[2])
         step = {mul_sum, p_q[XLEN-1:1]};
      else if (!div_diff[XLEN])   // no borrow: shifted remainder >= divisor
         step = {div_diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
      else
         step = {div_sh[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
   end

   // ---- final sign fix-up and result select on the last step ----
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, fin_res;

   assign prod_s = neg_q ? (~step + 1'b1) : step;
   assign quo_s  = neg_q ? (~step[XLEN-1:0] + 1'b1) : step[XLEN-1:0];
   assign rem_s  = neg_q ? (~step[2*XLEN-1:XLEN] + 1'b1) : step[2*XLEN-1:XLEN];

   always_comb begin
      case (op_q)
         3'd0:          fin_res = prod_s[XLEN-1:0];
         3'd1, 3'd2, 3'd3: fin_res = prod_s[2*XLEN-1:XLEN];
         3'd4, 3'd5:    fin_res = quo_s;
         default:       fin_res = rem_s;
      endcase
   end

   // ---- next state ----
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      b_d      = b_q;
      p_d      = p_q;
      neg_d    = neg_q;
      rd_lat_d = rd_lat_q;
      rd_d     = rd_q;
      rd_val_d = rd_val_q;
      done_d   = 1'b0;
      we_d     = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            op_d     = op;
            b_d      = b_mag;
            p_d      = {{XLEN{1'b0}}, a_mag};
            neg_d    = a_neg ^ (b_neg & (op != 3'd6));
            rd_lat_d = rd_in;
            if (div_zero || div_ovf) begin
               state_d  = DONE;
               rd_d     = rd_in;
               rd_val_d = fast_res;
               done_d   = 1'b1;
               we_d     = (rd_in != '0);
            end else begin
               state_d = CALC;
               cnt_d   = 5'd31;
            end
         end
         CALC: begin
            p_d = step;
            if (cnt_q == 5'd0) begin
               state_d  = DONE;
               rd_d     = rd_lat_q;
               rd_val_d = fin_res;
               done_d   = 1'b1;
               we_d     = (rd_lat_q != '0);
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // A flush aborts everything, including a start in the same cycle;
      // the visible write-back registers keep their old contents.
      if (kill) begin
         state_d  = IDLE;
         rd_d     = rd_q;
         rd_val_d = rd_val_q;
         done_d   = 1'b0;
         we_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         b_q      <= '0;
         p_q      <= '0;
         neg_q    <= 1'b0;
         rd_lat_q <= '0;
         rd_q     <= '0;
         rd_val_q <= '0;
         done_q   <= 1'b0;
         we_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         b_q      <= b_d;
         p_q      <= p_d;
         neg_q    <= neg_d;
         rd_lat_q <= rd_lat_d;
         rd_q     <= rd_d;
         rd_val_q <= rd_val_d;
         done_q   <= done_d;
         we_q     <= we_d;
      end
   end

   assign busy   = (state_q != IDLE);
   // kill must squash a write-back that is already on the outputs
   assign done   = done_q & ~kill;
   assign reg_we = we_q & ~kill;
   assign rd     = rd_q;
   assign rd_val = rd_val_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit.
- Takes operands read from the register bank (rs1_val, rs2_val) together with the destination index.
- Computes the result over multiple cycles, then drives a single-cycle write-back (rd, rd_val, reg_we) straight into the register bank write port.
- The issue stage uses busy to stall while an operation is in flight.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- ADDR_W, 5, register index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  issue request; sampled only in IDLE.
- op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_val  input  XLEN  operand A (dividend / multiplicand).
- rs2_val  input  XLEN  operand B (divisor / multiplier).
- rd_in  input  ADDR_W  destination register index.
- kill  input  1  pipeline flush; aborts any in-flight operation.
- busy  output  1  high while in CALC or DONE.
- done  output  1  one-cycle pulse, result valid.
- rd  output  ADDR_W  write-back index, valid when done=1.
- rd_val  output  XLEN  write-back data, valid when done=1.
- reg_we  output  1  write enable to register bank; equals done AND (rd != 0).

Behaviour:
- Reset (rst=1 at rising clk):
  - state = IDLE; busy, done and reg_we = 0; rd = 0; rd_val = 0.
  - Iteration counter and internal accumulators cleared.
  - rst overrides start and kill.
- States and transitions:
  - IDLE: on start=1, latch op, rd_in and both operands.
    - Fast path → DONE when op is DIV/DIVU/REM/REMU and rs2_val = 0, or when op = DIV/REM with rs1_val = 0x80000000 and rs2_val = 0xFFFFFFFF.
    - Otherwise → CALC with counter = 31.
  - CALC: one iteration per cycle.
    - counter = 0 → DONE; otherwise decrement.
    - Exactly 32 cycles in CALC.
  - DONE: done=1, reg_we per rule above, result held on rd_val. Next state IDLE unconditionally.
- Latency, with start accepted in cycle 0:
  - Normal: done in cycle 33; next start is accepted in cycle 34.
  - Fast path: done in cycle 1.
- start while busy=1 is ignored; no queueing. The issue stage must hold the instruction until busy=0.
- kill=1 in any cycle:
  - Next state = IDLE; done and reg_we forced to 0 in that same cycle (also in DONE).
  - start in the same IDLE cycle as kill is dropped.
- rd_val and rd retain their last value outside DONE; only done/reg_we qualify them.
- Operand signedness:
  - Signed ops (MULH, DIV, REM, and rs1 of MULHSU): convert to magnitude before iterating.
  - Result sign for MUL/MULH/DIV = sign(A) XOR sign(B).
  - Result sign for MULHSU = sign(A).
  - Result sign for REM = sign(A).
  - Two's-complement negation is applied once, on entry to DONE.
- Multiply: 64-bit shift-add accumulator over 32 steps.
  - MUL returns product[31:0].
  - MULH/MULHSU/MULHU return product[63:32].
- Divide: restoring, 1 quotient bit per step; 33-bit partial remainder.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Fast-path results:
  - Divide by zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = rs1_val.
  - Signed overflow: DIV = 0x80000000; REM = 0.
- rd_in = 0: the operation still runs full latency and done pulses, but reg_we stays 0.
- Operands are latched at start; later changes to rs1_val/rs2_val/rd_in have no effect.

Test Plan:
- Reset: hold rst 2 cycles → busy=0, done=0, reg_we=0, rd_val=0, rd=0.
- MUL 7×(−3) into rd=5 → done exactly 33 cycles after start, rd=5, rd_val=0xFFFFFFEB, reg_we=1. Then MULH 0x80000000×0x80000000 → rd_val=0x40000000. Then MULHSU 0xFFFFFFFF×0xFFFFFFFF → rd_val=0xFFFFFFFF.
- Division signs:
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFFF/16 → 0x0FFFFFFF.
  - REMU 100/7 → 2.
- Special cases, each with done 1 cycle after start:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Flow control: pulse start at cycle 10 of an in-flight DIV → ignored, exactly one done. rd_in=0 → done=1, reg_we=0. Back-to-back issue at cycle 34 is accepted.
- Abort: kill at cycle 15 of CALC → IDLE next cycle, no done/reg_we. kill coincident with DONE → reg_we=0. rst mid-CALC → all outputs return to reset values.
